// File: rtl/mem_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
// State encoding, MMIO offsets and the latched request bundle.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] LED_OFS   = 32'd0;
  localparam logic [31:0] CNT_OFS   = 32'd4;
  localparam logic [31:0] ERR_RDATA = 32'h0;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/multicycle_mem_responder_if.sv
// Request/response bus between the CPU datapath and the memory responder.
// The master drives requests, the slave answers with ready/addr_err.
interface multicycle_mem_responder_if;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        addr_err;
  logic        busy;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, addr_err, busy
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, addr_err, busy
  );

endinterface

// File: rtl/mem_ram_array.sv
// Unified instruction/data word RAM.
// Synchronous write, combinational read, contents not reset.
module mem_ram_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/multicycle_mem_responder.sv
// Memory-side responder: RAM, LED register and cycle counter,
// answered after a fixed number of wait states.
module multicycle_mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h4000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_mem_responder_if.slave    bus,
  output logic [7:0]                   leds
);

  localparam logic [32:0] RAM_BYTES = 33'd4 << ADDR_WIDTH;

  state_t      state;
  state_t      state_nxt;
  req_t        req_q;
  req_t        cur;
  logic [3:0]  wait_cnt;
  logic [31:0] cyc_cnt;
  logic [31:0] ram_rd;
  logic [31:0] rd_val;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        enter_resp;
  logic        sel_ram;
  logic        sel_led;
  logic        sel_cnt;
  logic        dec_err;
  logic        ram_we;

  assign accept = (state == IDLE) &&
                  (bus.mem_read || bus.mem_write);

  // With zero wait states the access happens on the
  // accepting edge, so decode straight from the bus.
  always_comb begin
    cur = req_q;
    if (state == IDLE) begin
      cur.rd    = bus.mem_read;
      cur.wr    = bus.mem_write;
      cur.addr  = bus.addr;
      cur.wdata = bus.wdata;
    end
  end

  always_comb begin
    sel_ram = 1'b0;
    sel_led = 1'b0;
    sel_cnt = 1'b0;
    dec_err = 1'b0;
    if (cur.rd && cur.wr)
      dec_err = 1'b1;
    else if (cur.addr[1:0] != 2'b00)
      dec_err = 1'b1;
    else if ({1'b0, cur.addr} < RAM_BYTES)
      sel_ram = 1'b1;
    else if (cur.addr == MMIO_BASE + LED_OFS)
      sel_led = 1'b1;
    else if (cur.addr == MMIO_BASE + CNT_OFS)
      sel_cnt = 1'b1;
    else
      dec_err = 1'b1;
  end

  always_comb begin
    rd_val = ERR_RDATA;
    unique case (1'b1)
      sel_ram: rd_val = ram_rd;
      sel_led: rd_val = {24'b0, leds};
      sel_cnt: rd_val = cyc_cnt;
      default: rd_val = ERR_RDATA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)
              state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (wait_cnt == 4'd1)
              state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state != IDLE);
    bus.ready    = (state == RESP);
    bus.addr_err = err_q;
    bus.rdata    = rdata_q;
  end

  assign enter_resp = (state_nxt == RESP) && (state != RESP);
  assign ram_we     = enter_resp && sel_ram && cur.wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q    <= '0;
      wait_cnt <= 4'd0;
      cyc_cnt  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      leds     <= 8'd0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (accept) begin
        req_q    <= cur;
        wait_cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q <= dec_err;
        if (dec_err)
          rdata_q <= ERR_RDATA;
        else if (cur.rd)
          rdata_q <= rd_val;
        if (sel_led && cur.wr)
          leds <= cur.wdata[7:0];
      end else if (state == RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  mem_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (cur.addr[ADDR_WIDTH+1:2]),
    .wdata (cur.wdata),
    .rdata (ram_rd)
  );

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Self-checking bench for multicycle_mem_responder.
// Scenario tasks compare DUT responses against a behavioural memory map model.
module tb_multicycle_mem_responder;

  localparam int          AW    = 8;
  localparam int          WC    = 2;
  localparam logic [31:0] MBASE = 32'h4000_0000;
  localparam int          WORDS = 2**AW;

  logic       clk;
  logic       reset;
  logic [7:0] leds;

  multicycle_mem_responder_if bus();

  multicycle_mem_responder #(
    .ADDR_WIDTH (AW),
    .WAIT_CYCLES(WC),
    .MMIO_BASE  (MBASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .leds (leds)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mmem [WORDS];
  logic [7:0]  mleds;
  logic [31:0] mrdata;
  logic [31:0] last_rd;
  int unsigned cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of counted clock edges since reset was released.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // 0 = error, 1 = RAM, 2 = LED, 3 = cycle counter
  function automatic int kind(bit rd, bit wr, logic [31:0] a);
    if (rd && wr)                 return 0;
    if (a % 4 != 0)               return 0;
    if (a < 32'(4 * WORDS))       return 1;
    if (a == MBASE)               return 2;
    if (a == MBASE + 32'd4)       return 3;
    return 0;
  endfunction

  task automatic txn(input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input string tag);
    int k;
    int lat;
    logic [31:0] exp_rd;
    logic        got_err;
    logic [31:0] got_rd;
    k = kind(rd, wr, a);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = $urandom;
    bus.wdata     = $urandom;
    lat = 0;
    while (bus.ready !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != WC) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, want %0d", tag, lat, WC);
      if (lat >= 20) return;
    end
    got_err = bus.addr_err;
    got_rd  = bus.rdata;
    if (k == 0) begin
      mrdata = 32'h0;
    end else if (rd) begin
      case (k)
        1: mrdata = mmem[a / 4];
        2: mrdata = {24'h0, mleds};
        default: mrdata = cyc - 1;
      endcase
    end else begin
      if (k == 1) mmem[a / 4] = d;
      if (k == 2) mleds = d[7:0];
    end
    exp_rd  = mrdata;
    last_rd = got_rd;
    checks++;
    if (got_err !== (k == 0)) begin
      errors++;
      $display("FAIL %s addr_err: got %b, want %b", tag, got_err, (k == 0));
    end
    checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL %s rdata: got %h, want %h", tag, got_rd, exp_rd);
    end
    checks++;
    if (leds !== mleds || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s leds/busy: got %h/%b, want %h/1",
               tag, leds, bus.busy, mleds);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b0 || bus.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL %s release: ready/busy/err got %b%b%b, want 000",
               tag, bus.ready, bus.busy, bus.addr_err);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b0 || bus.addr_err !== 1'b0 ||
        bus.rdata !== 32'h0 || leds !== 8'h0) begin
      errors++;
      $display("FAIL reset: rdy=%b busy=%b err=%b rdata=%h leds=%h, want 0s",
               bus.ready, bus.busy, bus.addr_err, bus.rdata, leds);
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < WORDS; i++)
      txn(1'b0, 1'b1, 32'(i * 4), $urandom, "preload");
  endtask

  task automatic test_write_read();
    txn(1'b0, 1'b1, 32'h10, 32'h1234_5678, "wr_10");
    txn(1'b1, 1'b0, 32'h10, 32'h0, "rd_10");
  endtask

  task automatic test_errors();
    txn(1'b1, 1'b0, 32'h0000_0006, 32'h0, "misaligned");
    txn(1'b1, 1'b0, 32'h10, 32'h0, "rd_10_again");
    txn(1'b1, 1'b0, 32'h0000_2000, 32'h0, "out_of_range");
    txn(1'b0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF, "wr_misaligned");
    txn(1'b1, 1'b0, 32'h4, 32'h0, "rd_4");
  endtask

  task automatic test_leds();
    txn(1'b0, 1'b1, MBASE, 32'hFFFF_FFA5, "led_wr");
    txn(1'b1, 1'b0, MBASE, 32'h0, "led_rd");
  endtask

  task automatic test_counter();
    logic [31:0] v1;
    txn(1'b1, 1'b0, MBASE + 32'd4, 32'h0, "cnt_rd1");
    v1 = last_rd;
    repeat (6) @(posedge clk);
    #1;
    txn(1'b1, 1'b0, MBASE + 32'd4, 32'h0, "cnt_rd2");
    checks++;
    if (last_rd - v1 !== 32'd10) begin
      errors++;
      $display("FAIL cnt_diff: got %0d, want 10", last_rd - v1);
    end
    txn(1'b0, 1'b1, MBASE + 32'd4, 32'h0, "cnt_wr");
    txn(1'b1, 1'b0, MBASE + 32'd4, 32'h0, "cnt_rd3");
  endtask

  task automatic test_both();
    txn(1'b0, 1'b1, 32'h20, 32'hAAAA_AAAA, "wr_20");
    txn(1'b1, 1'b1, 32'h20, 32'h5555_5555, "rd_and_wr");
    txn(1'b1, 1'b0, 32'h20, 32'h0, "rd_20");
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    int pulses;
    first  = -1;
    second = -1;
    pulses = 0;
    bus.mem_read = 1'b1;
    bus.addr     = 32'h40;
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) begin
        pulses++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
        checks++;
        if (bus.rdata !== mmem[16]) begin
          errors++;
          $display("FAIL b2b rdata: got %h, want %h", bus.rdata, mmem[16]);
        end
        if (pulses == 2) bus.mem_read = 1'b0;
      end
    end
    bus.mem_read = 1'b0;
    mrdata = mmem[16];
    checks++;
    if (first != WC || second != 2 * WC + 2 || pulses != 2) begin
      errors++;
      $display("FAIL b2b timing: ready at %0d,%0d (%0d pulses), want %0d,%0d",
               first, second, pulses, WC, 2 * WC + 2);
    end
  endtask

  task automatic test_random();
    bit rd;
    bit wr;
    int op;
    logic [31:0] a;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      rd = (op < 5) || (op == 9);
      wr = (op >= 5);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, WORDS - 1) * 4);
        6: a = 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
        7: a = MBASE;
        8: a = MBASE + 32'd4;
        default: a = 32'h1000 + 32'($urandom_range(0, 4000) * 4);
      endcase
      txn(rd, wr, a, $urandom, "random");
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] old;
    old = mmem[12];
    bus.mem_write = 1'b1;
    bus.addr      = 32'h30;
    bus.wdata     = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort busy_before: got %b, want 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || leds !== 8'h0 ||
        bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort outputs: busy=%b ready=%b leds=%h rdata=%h, want 0s",
               bus.busy, bus.ready, leds, bus.rdata);
    end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mleds  = 8'h0;
    mrdata = 32'h0;
    repeat (WC + 2) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort idle: ready=%b busy=%b, want 0 0",
               bus.ready, bus.busy);
    end
    txn(1'b1, 1'b0, 32'h30, 32'h0, "rd_30_after_abort");
    checks++;
    if (last_rd !== old) begin
      errors++;
      $display("FAIL abort ram: got %h, want %h", last_rd, old);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    mleds         = 8'h0;
    mrdata        = 32'h0;
    last_rd       = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_preload();
    test_write_read();
    test_errors();
    test_leds();
    test_counter();
    test_both();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
